// File: rtl/edf_ic_pkg.sv
// Shared definitions for the EDF interrupt controller: config address map,
// scheduler state encoding and the default deadline width.
package edf_ic_pkg;

    localparam int          DefDlWidth = 16;

    localparam logic [31:0] RelDlBase  = 32'h0000_0000;
    localparam logic [31:0] EnAddr     = 32'h0000_0040;
    localparam logic [31:0] OvfAddr    = 32'h0000_0044;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        PUSH
    } sched_state_e;

endpackage

// File: rtl/edf_cfg_regs.sv
// Config register block of the EDF scheduler: per-line relative deadlines,
// line enables and sticky overflow flags (write-1-to-clear).
module edf_cfg_regs
    import edf_ic_pkg::*;
#(
    parameter int NrParIrqs = 4,
    parameter int DlWidth   = DefDlWidth
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cfg_req_i,
    input  logic [31:0]                    cfg_addr_i,
    input  logic [31:0]                    cfg_wdata_i,
    input  logic [NrParIrqs-1:0]           ovf_set_i,
    output logic [NrParIrqs*DlWidth-1:0]   rel_dl_o,
    output logic [NrParIrqs-1:0]           en_o,
    output logic [NrParIrqs-1:0]           ovf_o
);

    logic [NrParIrqs-1:0][DlWidth-1:0] relDl_q, relDl_d;
    logic [NrParIrqs-1:0]              en_q, en_d;
    logic [NrParIrqs-1:0]              ovf_q, ovf_d;
    logic                              unusedWdata;

    assign unusedWdata = ^cfg_wdata_i;

    // A drop reported in the same cycle as a clear wins, so no event is lost.
    always_comb begin
        relDl_d = relDl_q;
        en_d    = en_q;
        ovf_d   = ovf_q;
        if (cfg_req_i) begin
            for (int i = 0; i < NrParIrqs; i++) begin
                if (cfg_addr_i == RelDlBase + 32'(4 * i)) begin
                    relDl_d[i] = cfg_wdata_i[DlWidth-1:0];
                end
            end
            if (cfg_addr_i == EnAddr) begin
                en_d = cfg_wdata_i[NrParIrqs-1:0];
            end
            if (cfg_addr_i == OvfAddr) begin
                ovf_d = ovf_q & ~cfg_wdata_i[NrParIrqs-1:0];
            end
        end
        ovf_d = ovf_d | ovf_set_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            relDl_q <= '1;
            en_q    <= '0;
            ovf_q   <= '0;
        end else begin
            relDl_q <= relDl_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rel_dl_o = relDl_q;
    assign en_o     = en_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/edf_irq_sched.sv
// EDF scheduler front end: stamps rising IRQ edges with absolute deadlines and
// offers them one at a time to the priority queue, tracking in-flight lines.
module edf_irq_sched
    import edf_ic_pkg::*;
#(
    parameter  int NrParIrqs = 4,
    parameter  int DlWidth   = DefDlWidth,
    localparam int IdWidth   = $clog2(NrParIrqs)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_req_i,
    input  logic [31:0]          cfg_addr_i,
    input  logic [31:0]          cfg_wdata_i,
    input  logic [NrParIrqs-1:0] irq_i,
    output logic                 push_valid_o,
    input  logic                 push_ready_i,
    output logic [IdWidth-1:0]   push_id_o,
    output logic [DlWidth-1:0]   push_dl_o,
    input  logic                 done_i,
    input  logic [IdWidth-1:0]   done_id_i,
    output logic [DlWidth-1:0]   time_o,
    output logic [NrParIrqs-1:0] ovf_o
);

    logic [NrParIrqs-1:0][DlWidth-1:0] relDl;
    logic [NrParIrqs-1:0]              en;
    logic [NrParIrqs-1:0]              ovfSet;

    logic [DlWidth-1:0]                time_q;
    logic [NrParIrqs-1:0]              irq_q;
    logic [NrParIrqs-1:0]              pending_q, pending_d;
    logic [NrParIrqs-1:0]              inflight_q, inflight_d;
    logic [NrParIrqs-1:0][DlWidth-1:0] absDl_q, absDl_d;

    sched_state_e                      state_q, state_d;
    logic [IdWidth-1:0]                ptr_q, ptr_d;
    logic [IdWidth-1:0]                pushId_q, pushId_d;
    logic [DlWidth-1:0]                pushDl_q, pushDl_d;

    logic [NrParIrqs-1:0]              edgeDet;
    logic [NrParIrqs-1:0]              doneMask;
    logic [NrParIrqs-1:0]              ptrMask;
    logic [NrParIrqs-1:0]              pendKeep;
    logic                              handshake;

    edf_cfg_regs #(
        .NrParIrqs (NrParIrqs),
        .DlWidth   (DlWidth)
    ) i_cfg_regs (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cfg_req_i   (cfg_req_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_wdata_i (cfg_wdata_i),
        .ovf_set_i   (ovfSet),
        .rel_dl_o    (relDl),
        .en_o        (en),
        .ovf_o       (ovf_o)
    );

    assign edgeDet   = irq_i & ~irq_q & en;
    assign doneMask  = done_i ? (NrParIrqs'(1) << done_id_i) : '0;
    assign ptrMask   = NrParIrqs'(1) << ptr_q;
    assign handshake = (state_q == PUSH) && push_ready_i;
    assign pendKeep  = en | ((state_q == PUSH) ? ptrMask : '0);

    // A line already offered keeps its pending bit through a disable so the
    // open handshake can still complete; a same-cycle done frees the line first.
    always_comb begin
        pending_d  = pending_q;
        inflight_d = inflight_q & ~doneMask;
        absDl_d    = absDl_q;
        ovfSet     = '0;
        if (handshake) begin
            pending_d  = pending_d & ~ptrMask;
            inflight_d = inflight_d | ptrMask;
        end
        pending_d = pending_d & pendKeep;
        for (int i = 0; i < NrParIrqs; i++) begin
            if (edgeDet[i]) begin
                if (!pending_q[i] && !(inflight_q[i] && !doneMask[i])) begin
                    pending_d[i] = 1'b1;
                    absDl_d[i]   = time_q + relDl[i];
                end else begin
                    ovfSet[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            time_q     <= '0;
            irq_q      <= '0;
            pending_q  <= '0;
            inflight_q <= '0;
            absDl_q    <= '0;
        end else begin
            time_q     <= time_q + 1'b1;
            irq_q      <= irq_i;
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            absDl_q    <= absDl_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            pushId_q <= '0;
            pushDl_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            pushId_q <= pushId_d;
            pushDl_q <= pushDl_d;
        end
    end

    // Round-robin scan from the pointer; a hit latches id and deadline so they
    // stay stable for the whole offer.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        pushId_d = pushId_q;
        pushDl_d = pushDl_q;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (pending_q == '0) begin
                    state_d = IDLE;
                end else if (pending_q[ptr_q] && en[ptr_q]) begin
                    state_d  = PUSH;
                    pushId_d = ptr_q;
                    pushDl_d = absDl_q[ptr_q];
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            PUSH: begin
                if (push_ready_i) begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = (pending_d != '0) ? SCAN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_valid_o = (state_q == PUSH);
        push_id_o    = pushId_q;
        push_dl_o    = pushDl_q;
        time_o       = time_q;
    end

endmodule

// File: tb/tb_edf_irq_sched.sv
// Directed self-checking bench for edf_irq_sched: deadline stamping, wrap,
// ordering, overflow/drop handling, line disable and asynchronous reset.
module tb_edf_irq_sched;

    logic        clk;
    logic        rst;
    logic        cfgReq;
    logic [31:0] cfgAddr;
    logic [31:0] cfgWdata;
    logic [3:0]  irq;
    logic        pushReady;
    logic        doneValid;
    logic [1:0]  doneId;

    logic        pushValid;
    logic [1:0]  pushId;
    logic [15:0] pushDl;
    logic [15:0] timeOut;
    logic [3:0]  ovf;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] tbTime;
    logic [15:0] expDl;

    edf_irq_sched #(
        .NrParIrqs (4),
        .DlWidth   (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_req_i    (cfgReq),
        .cfg_addr_i   (cfgAddr),
        .cfg_wdata_i  (cfgWdata),
        .irq_i        (irq),
        .push_valid_o (pushValid),
        .push_ready_i (pushReady),
        .push_id_o    (pushId),
        .push_dl_o    (pushDl),
        .done_i       (doneValid),
        .done_id_i    (doneId),
        .time_o       (timeOut),
        .ovf_o        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference free-running time: counts clock edges since the last reset.
    always @(posedge clk or posedge rst) begin
        if (rst) tbTime <= 16'd0;
        else     tbTime <= tbTime + 16'd1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic cfgWrite(input logic [31:0] addr, input logic [31:0] data);
        cfgReq   = 1'b1;
        cfgAddr  = addr;
        cfgWdata = data;
        @(negedge clk);
        cfgReq   = 1'b0;
        cfgAddr  = '0;
        cfgWdata = '0;
    endtask

    task automatic waitValid(input string tag, input int budget);
        int n = 0;
        while (pushValid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(pushValid), 32'd1);
    endtask

    task automatic doReset();
        irq       = '0;
        pushReady = 1'b0;
        doneValid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b1;
        cfgReq    = 1'b0;
        cfgAddr   = '0;
        cfgWdata  = '0;
        irq       = '0;
        pushReady = 1'b0;
        doneValid = 1'b0;
        doneId    = '0;
        applyStimulus(2);
        rst = 1'b0;

        checkOutput("rstValid", 32'(pushValid), 32'd0);
        checkOutput("rstId", 32'(pushId), 32'd0);
        checkOutput("rstDl", 32'(pushDl), 32'd0);
        checkOutput("rstOvf", 32'(ovf), 32'd0);
        checkOutput("rstTime", 32'(timeOut), 32'd0);
        applyStimulus(10);
        checkOutput("idleTime", 32'(timeOut), 32'd10);
        checkOutput("idleValid", 32'(pushValid), 32'd0);
        checkOutput("idleOvf", 32'(ovf), 32'd0);

        // Line 2, rel 0x20, edge at time 5, offer held while ready is low.
        doReset();
        cfgWrite(32'h08, 32'h20);
        cfgWrite(32'h40, 32'hF);
        applyStimulus(3);
        checkOutput("s2Time", 32'(timeOut), 32'd5);
        irq = 4'b0100;
        waitValid("s2Valid", 10);
        checkOutput("s2Id", 32'(pushId), 32'd2);
        checkOutput("s2Dl", 32'(pushDl), 32'h25);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1);
            checkOutput("s2HoldValid", 32'(pushValid), 32'd1);
            checkOutput("s2HoldId", 32'(pushId), 32'd2);
            checkOutput("s2HoldDl", 32'(pushDl), 32'h25);
        end
        pushReady = 1'b1;
        applyStimulus(1);
        pushReady = 1'b0;
        irq       = '0;
        checkOutput("s2AfterHs", 32'(pushValid), 32'd0);

        // All lines same cycle, rel = reset 0xFFFF, edge at time 1 -> dl 0.
        doReset();
        cfgWrite(32'h40, 32'hF);
        checkOutput("s3Time", 32'(timeOut), 32'd1);
        irq       = 4'b1111;
        pushReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waitValid("s3Valid", 10);
            checkOutput("s3Id", 32'(pushId), 32'(k));
            checkOutput("s3Dl", 32'(pushDl), 32'h0000);
            applyStimulus(1);
        end
        pushReady = 1'b0;
        irq       = '0;
        checkOutput("s3Drained", 32'(pushValid), 32'd0);
        checkOutput("s3Ovf", 32'(ovf), 32'd0);

        // Line 3 in flight: second edge dropped, flag cleared, done re-arms it.
        applyStimulus(1);
        irq = 4'b1000;
        applyStimulus(1);
        checkOutput("s4OvfSet", 32'(ovf), 32'h8);
        checkOutput("s4NoPush", 32'(pushValid), 32'd0);
        irq = '0;
        cfgWrite(32'h44, 32'h8);
        checkOutput("s4OvfClr", 32'(ovf), 32'h0);
        doneValid = 1'b1;
        doneId    = 2'd3;
        applyStimulus(1);
        doneValid = 1'b0;
        irq       = 4'b1000;
        expDl     = tbTime + 16'hFFFF;
        waitValid("s4Valid", 10);
        checkOutput("s4Id", 32'(pushId), 32'd3);
        checkOutput("s4Dl", 32'(pushDl), 32'(expDl));
        pushReady = 1'b1;
        applyStimulus(1);
        pushReady = 1'b0;
        irq       = '0;
        checkOutput("s4OvfStill", 32'(ovf), 32'h0);

        // Line 0 disabled: an edge produces neither an offer nor an overflow.
        cfgWrite(32'h40, 32'hE);
        irq = 4'b0001;
        applyStimulus(6);
        checkOutput("s5NoPush", 32'(pushValid), 32'd0);
        checkOutput("s5NoOvf", 32'(ovf), 32'h0);
        irq = '0;

        // Reset asserted mid-offer drops the offer without waiting for a clock.
        doneValid = 1'b1;
        doneId    = 2'd1;
        applyStimulus(1);
        doneValid = 1'b0;
        irq       = 4'b0010;
        waitValid("s6Valid", 10);
        checkOutput("s6Id", 32'(pushId), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("s6RstValid", 32'(pushValid), 32'd0);
        checkOutput("s6RstId", 32'(pushId), 32'd0);
        checkOutput("s6RstDl", 32'(pushDl), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        irq = '0;
        checkOutput("s6RstTime", 32'(timeOut), 32'd0);

        // Deadline wrap: rel 0x10 at time 0xFFF8 gives 0x0008.
        cfgWrite(32'h04, 32'h10);
        cfgWrite(32'h40, 32'h2);
        while (tbTime != 16'hFFF8) @(negedge clk);
        checkOutput("s7Time", 32'(timeOut), 32'hFFF8);
        irq = 4'b0010;
        waitValid("s7Valid", 10);
        checkOutput("s7Id", 32'(pushId), 32'd1);
        checkOutput("s7Dl", 32'(pushDl), 32'h0008);
        irq = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
